// File: rtl/display_arbiter.sv
// display_arbiter: shares the 4-digit hex panel among alarm (preemptive), status and reading
// requesters with minimum hold time, round-robin between the non-alarm pair and alarm dot blink.
`default_nettype none

module display_arbiter #(
  parameter int unsigned HOLD_CYC  = 50_000_000,
  parameter int unsigned BLINK_CYC = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [3:0]  hexa3,
  output logic [3:0]  hexa2,
  output logic [3:0]  hexa1,
  output logic [3:0]  hexa0,
  output logic [3:0]  puntos4
);

  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALARM  = 2'd1,
    ST_STATUS = 2'd2,
    ST_READ   = 2'd3
  } state_t;

  state_t        state_q, state_d, idle_sel;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          rr_read_q, rr_read_d;   // 1: reading (owner 2) was granted last
  logic [2:0]    grant_q, grant_d;
  logic [15:0]   hex_q, hex_d;
  logic [3:0]    puntos_q, puntos_d;
  logic          restart;
  logic          hold_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      rr_read_q   <= 1'b1;
      grant_q     <= 3'b000;
      hex_q       <= 16'h0000;
      puntos_q    <= 4'hf;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      rr_read_q   <= rr_read_d;
      grant_q     <= grant_d;
      hex_q       <= hex_d;
      puntos_q    <= puntos_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    restart      = 1'b0;
    hold_expired = (hold_q == HOLD_LAST);

    if (req[1] && req[2])  idle_sel = rr_read_q ? ST_STATUS : ST_READ;
    else if (req[1])       idle_sel = ST_STATUS;
    else if (req[2])       idle_sel = ST_READ;
    else                   idle_sel = ST_IDLE;

    case (state_q)
      ST_STATUS: begin
        if (!req[1])          state_d = idle_sel;
        else if (hold_expired) begin
          if (req[2])         state_d = ST_READ;
          else                restart = 1'b1;
        end
      end
      ST_READ: begin
        if (!req[2])          state_d = idle_sel;
        else if (hold_expired) begin
          if (req[1])         state_d = ST_STATUS;
          else                restart = 1'b1;
        end
      end
      default:                state_d = idle_sel;
    endcase

    // Alarm overrides everything, regardless of the hold timer.
    if (req[0]) begin
      state_d = ST_ALARM;
      restart = 1'b0;
    end

    if ((state_d != state_q) || restart)                 hold_d = '0;
    else if ((state_q == ST_STATUS) || (state_q == ST_READ))
      hold_d = hold_expired ? hold_q : hold_q + HW'(1);
    else                                                 hold_d = '0;

    rr_read_d = rr_read_q;
    if (state_d == ST_STATUS) rr_read_d = 1'b0;
    if (state_d == ST_READ)   rr_read_d = 1'b1;

    // Fresh alarm tenure starts with dots off for a full half-period.
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if ((state_d == ST_ALARM) && (state_q == ST_ALARM)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
      end
    end

    case (state_d)
      ST_ALARM:  begin grant_d = 3'b001; hex_d = data0;    end
      ST_STATUS: begin grant_d = 3'b010; hex_d = data1;    end
      ST_READ:   begin grant_d = 3'b100; hex_d = data2;    end
      default:   begin grant_d = 3'b000; hex_d = 16'h0000; end
    endcase

    puntos_d = ((state_d == ST_ALARM) && blink_d) ? 4'h0 : 4'hf;
  end

  assign grant   = grant_q;
  assign hexa3   = hex_q[15:12];
  assign hexa2   = hex_q[11:8];
  assign hexa1   = hex_q[7:4];
  assign hexa0   = hex_q[3:0];
  assign puntos4 = puntos_q;

endmodule

`default_nettype wire

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 4-digit hex panel (`Timemultiplexhexa`) among three requesters: alarm code from `maquinaestados` (priority, preemptive), system status, and current-sensor reading. It uses a request/grant handshake, a minimum hold time per owner, and round-robin between the two non-alarm requesters. While the alarm owns the panel, the decimal points blink. It sits between the requesters and the `hexa3..hexa0`/`puntos4` inputs of the panel multiplexer in `Proyecto1`.

## Interface
- `HOLD_CYC`, 50_000_000: minimum cycles a non-alarm owner keeps the panel before rotation (≥2).
- `BLINK_CYC`, 12_500_000: half-period of the alarm decimal-point blink, in cycles (≥1).
- `clk` in 1: system clock; all state on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 3: requests; bit0 alarm, bit1 status, bit2 reading.
- `data0`, `data1`, `data2` in 16 each: 4 hex nibbles per requester; [15:12]→hexa3 … [3:0]→hexa0.
- `grant` out 3: one-hot current owner; 3'b000 when idle.
- `hexa3`, `hexa2`, `hexa1`, `hexa0` out 4 each: digits to the panel.
- `puntos4` out 4: decimal points to the panel; 4'hf = all off.

## Operation
- States: IDLE (no owner), OWN (owner ∈ {0,1,2}).
- Next-owner selection (combinational), registered into `grant`/digits on the same edge:
  - `req[0]` high → owner 0. This applies from any state and preempts 1/2 immediately, regardless of hold.
  - Owner 0 with `req[0]` low → behaves as IDLE for selection.
  - IDLE: pick among `req[2:1]`. If both are high, pick the one not equal to `last_rr`. `last_rr` resets to 2, so 1 wins first. Neither high → stay IDLE.
  - Owner 1/2, own req dropped → release that edge; select as IDLE (other one may take over same edge).
  - Owner 1/2, own req held, hold expired (`hold_cnt == HOLD_CYC-1`):
    - If the other non-alarm req is high → switch to it.
    - Otherwise keep the owner and restart `hold_cnt`.
  - Owner 1/2 before expiry, own req held → keep.
- `last_rr` updates to 1 or 2 whenever 1 or 2 is granted.
- `hold_cnt`: width $clog2(HOLD_CYC). Cleared on every owner change and on restart; otherwise increments by 1 while owner is 1/2; saturates at HOLD_CYC-1. It is frozen at 0 while owner is 0 or IDLE.
- Digits: each edge, `hexa*` ← nibbles of next owner's `dataN`. When next is IDLE, `hexa*` ← 4'h0.
- Blink: `blink_cnt` (width $clog2(BLINK_CYC)) runs only while owner is 0. It wraps at BLINK_CYC-1 and toggles `blink`.
  - `puntos4` = 4'h0 when `blink`=1, else 4'hf.
  - Entering owner 0 clears `blink_cnt` and `blink`, so the first half-period is dots off.
  - Non-alarm or IDLE → `puntos4`=4'hf.
- Reset (async assert, any time, including mid-hold or mid-blink):
  - `grant`=0, `hexa*`=0, `puntos4`=4'hf.
  - Counters 0, `blink`=0, `last_rr`=2, state IDLE.
  - Release is synchronous to next `clk` edge; the first grant can occur on the first edge after release.

## Timing
- Latency: `req` sampled at edge k → `grant` and digits valid after edge k (1 cycle). No combinational path from `req`/`data*` to outputs.
- Data tracking: owner's `dataN` change at cycle k appears on `hexa*` after edge k.
- Hand-over is glitch-free: `grant` never has more than one bit set; new owner's data appears in the same cycle as its grant.
- Non-alarm tenure with contention = exactly HOLD_CYC cycles of `grant` high.
- Blink period = 2·BLINK_CYC cycles.
- Requester handshake: a requester holds `req` until it sees `grant`. Deasserting before grant is legal (request withdrawn, no grant).

## Test plan
Parameters: HOLD_CYC=8, BLINK_CYC=4.

1. Reset behaviour: assert `rst`=0 mid-operation → outputs immediately `grant`=0, `hexa*`=0, `puntos4`=4'hf. Release, raise `req`=3'b110 same edge → `grant`=3'b010 next cycle (`last_rr` reset favours 1).
2. Round-robin: `req`=3'b110 held, `data1`=16'h1234, `data2`=16'hABCD → `grant`=010 for 8 cycles showing 1,2,3,4. Then 100 for 8 cycles showing A,B,C,D. Then it alternates.
3. Preemption: owner 2 at hold_cnt=3, raise `req[0]` with `data0`=16'hE001 → next cycle `grant`=001, digits E,0,0,1. `puntos4` shows f×4 cycles, then 0×4, repeating. Drop `req[0]` → next cycle `grant`=100 with `hold_cnt` restarted.
4. Early release: owner 1 drops `req[1]` at hold_cnt=2 while `req[2]` high → `grant`=100 next cycle. Both requests dropped instead → `grant`=000, `hexa*`=0.
5. Sole requester: only `req[1]` for 30 cycles → `grant` stays 010 continuously. Live `data1` change 16'h0000→16'h0042 appears one cycle later.
